// File: rtl/ccu_isa_fetch_pkg.sv
// rtl/ccu_isa_fetch_pkg.sv - shared ISA fetch constants: opcodes, instruction lengths, FSM states
package ccu_isa_fetch_pkg;

  localparam int PORT_WIDTH   = 128;
  localparam int ADDR_WIDTH   = 16;
  localparam int OPCODE_WIDTH = 8;
  localparam int NUM_OP       = 5;
  localparam int BUF_DEPTH    = 4;
  localparam int BUF_AW       = $clog2(BUF_DEPTH);
  localparam int CNT_W        = BUF_AW + 1;

  localparam logic [OPCODE_WIDTH-1:0] OPCODE_FPS = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_KNN = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_SYA = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_POL = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_GIC = OPCODE_WIDTH'(4);

  localparam logic [ADDR_WIDTH-1:0] LEN_FPS = ADDR_WIDTH'(16);
  localparam logic [ADDR_WIDTH-1:0] LEN_KNN = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] LEN_SYA = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] LEN_POL = ADDR_WIDTH'(9);
  localparam logic [ADDR_WIDTH-1:0] LEN_GIC = ADDR_WIDTH'(2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } isa_state_e;

  // Words per instruction, header included; illegal opcodes map to 0.
  function automatic logic [ADDR_WIDTH-1:0] op_len(input logic [OPCODE_WIDTH-1:0] op);
    logic [ADDR_WIDTH-1:0] len;
    len = '0;
    case (op)
      OPCODE_FPS: len = LEN_FPS;
      OPCODE_KNN: len = LEN_KNN;
      OPCODE_SYA: len = LEN_SYA;
      OPCODE_POL: len = LEN_POL;
      OPCODE_GIC: len = LEN_GIC;
      default:    len = '0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ccu_isa_fetch_fifo.sv
// rtl/ccu_isa_fetch_fifo.sv - FIFO_FWFT: first-word-fall-through buffer, head visible the cycle after write
module FIFO_FWFT #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [ADDR_WIDTH:0]   count_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push_i && (count_q != (ADDR_WIDTH+1)'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  // Storage is reset so the head reads zero out of reset.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (ADDR_WIDTH+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_WIDTH+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ccu_isa_fetch.sv
// rtl/ccu_isa_fetch.sv - reads an ISA program from GLB and streams it to the CCU with framing checks
module ccu_isa_fetch
  import ccu_isa_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  TOPITF_IsaStart,
  input  logic [ADDR_WIDTH-1:0] TOPITF_IsaBaseAddr,
  input  logic [ADDR_WIDTH-1:0] TOPITF_IsaNumWord,
  output logic                  ITFTOP_IsaDone,
  output logic                  ITFTOP_IsaErr,
  output logic [ADDR_WIDTH-1:0] ITFGLB_RdAddr,
  output logic                  ITFGLB_RdAddrVld,
  input  logic                  GLBITF_RdAddrRdy,
  input  logic [PORT_WIDTH-1:0] GLBITF_RdDat,
  input  logic                  GLBITF_RdDatVld,
  output logic                  ITFGLB_RdDatRdy,
  output logic [PORT_WIDTH-1:0] ITFCCU_ISARdDat,
  output logic                  ITFCCU_ISARdDatVld,
  input  logic                  CCUITF_ISARdDatRdy
);

  isa_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] num_q, num_d;
  logic [ADDR_WIDTH-1:0] issued_q, issued_d;
  logic [ADDR_WIDTH-1:0] sent_q, sent_d;
  logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] inst_len_q, inst_len_d;
  logic [CNT_W-1:0]      outst_q, outst_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [CNT_W-1:0]        buf_cnt;
  logic [CNT_W:0]          credit_use;
  logic [PORT_WIDTH-1:0]   head;
  logic [OPCODE_WIDTH-1:0] head_op;
  logic [ADDR_WIDTH-1:0]   cur_len;
  logic [ADDR_WIDTH-1:0]   word_cnt_inc;
  logic                    buf_empty;
  logic                    is_header;
  logic                    hdr_legal;
  logic                    req_vld;
  logic                    req_hs;
  logic                    out_vld;
  logic                    out_hs;
  logic                    buf_push;
  logic                    buf_pop;

  FIFO_FWFT #(
    .DATA_WIDTH (PORT_WIDTH),
    .ADDR_WIDTH (BUF_AW)
  ) u_buf (
    .clk     (clk),
    .Reset   (rst),
    .push_i  (buf_push),
    .data_i  (GLBITF_RdDat),
    .pop_i   (buf_pop),
    .data_o  (head),
    .count_o (buf_cnt)
  );

  assign buf_empty    = (buf_cnt == '0);
  assign head_op      = head[OPCODE_WIDTH-1:0];
  assign is_header    = (word_cnt_q == '0);
  assign hdr_legal    = (head_op < OPCODE_WIDTH'(NUM_OP));
  assign cur_len      = is_header ? op_len(head_op) : inst_len_q;
  assign word_cnt_inc = word_cnt_q + ADDR_WIDTH'(1);

  // Credit counts words in flight plus words buffered, so a response always has a slot.
  assign credit_use = {1'b0, outst_q} + {1'b0, buf_cnt};
  assign req_vld    = (state_q == ST_RUN) && (issued_q != num_q) &&
                      (credit_use < (CNT_W+1)'(BUF_DEPTH));
  assign req_hs     = req_vld && GLBITF_RdAddrRdy;

  assign out_vld  = (state_q == ST_RUN) && !buf_empty && (!is_header || hdr_legal);
  assign out_hs   = out_vld && CCUITF_ISARdDatRdy;
  assign buf_push = GLBITF_RdDatVld && (state_q == ST_RUN);
  // In ERR the buffer is flushed so the next program starts empty.
  assign buf_pop  = out_hs || ((state_q == ST_ERR) && !buf_empty);

  always_comb begin
    outst_d = outst_q;
    case ({req_hs, GLBITF_RdDatVld})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    num_d      = num_q;
    issued_d   = issued_q;
    sent_d     = sent_q;
    word_cnt_d = word_cnt_q;
    inst_len_d = inst_len_q;
    done_d     = 1'b0;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (TOPITF_IsaStart) begin
          base_d     = TOPITF_IsaBaseAddr;
          num_d      = TOPITF_IsaNumWord;
          issued_d   = '0;
          sent_d     = '0;
          word_cnt_d = '0;
          inst_len_d = '0;
          err_d      = 1'b0;
          if (TOPITF_IsaNumWord == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (req_hs) begin
          issued_d = issued_q + ADDR_WIDTH'(1);
        end
        if (!buf_empty && is_header && !hdr_legal) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else if (out_hs) begin
          sent_d     = sent_q + ADDR_WIDTH'(1);
          word_cnt_d = (word_cnt_inc == cur_len) ? '0 : word_cnt_inc;
          if (is_header) begin
            inst_len_d = cur_len;
          end
          // Last program word: a clean finish must also close the instruction.
          if (sent_q + ADDR_WIDTH'(1) == num_q) begin
            if (word_cnt_inc == cur_len) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_ERR;
            end
          end
        end
      end
      ST_ERR: begin
        if ((outst_q == '0) && buf_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      word_cnt_q <= '0;
      inst_len_q <= '0;
      outst_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      word_cnt_q <= word_cnt_d;
      inst_len_q <= inst_len_d;
      outst_q    <= outst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ITFTOP_IsaDone     = done_q;
  assign ITFTOP_IsaErr      = err_q;
  assign ITFGLB_RdAddr      = base_q + issued_q;
  assign ITFGLB_RdAddrVld   = req_vld;
  assign ITFGLB_RdDatRdy    = 1'b1;
  assign ITFCCU_ISARdDat    = head;
  assign ITFCCU_ISARdDatVld = out_vld;

endmodule

// File: tb/tb_ccu_isa_fetch.sv
// tb/tb_ccu_isa_fetch.sv - self-checking bench for ccu_isa_fetch
module tb_ccu_isa_fetch;

  logic         clk;
  logic         rst;
  logic         start;
  logic [15:0]  base_in;
  logic [15:0]  num_in;
  logic         done;
  logic         err;
  logic [15:0]  rd_addr;
  logic         rd_addr_vld;
  logic         rd_addr_rdy;
  logic [127:0] rd_dat;
  logic         rd_dat_vld;
  logic         rd_dat_rdy;
  logic [127:0] isa_dat;
  logic         isa_vld;
  logic         isa_rdy;

  ccu_isa_fetch dut (
    .clk                (clk),
    .rst                (rst),
    .TOPITF_IsaStart    (start),
    .TOPITF_IsaBaseAddr (base_in),
    .TOPITF_IsaNumWord  (num_in),
    .ITFTOP_IsaDone     (done),
    .ITFTOP_IsaErr      (err),
    .ITFGLB_RdAddr      (rd_addr),
    .ITFGLB_RdAddrVld   (rd_addr_vld),
    .GLBITF_RdAddrRdy   (rd_addr_rdy),
    .GLBITF_RdDat       (rd_dat),
    .GLBITF_RdDatVld    (rd_dat_vld),
    .ITFGLB_RdDatRdy    (rd_dat_rdy),
    .ITFCCU_ISARdDat    (isa_dat),
    .ITFCCU_ISARdDatVld (isa_vld),
    .CCUITF_ISARdDatRdy (isa_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [15:0]     base;
    logic [15:0]     num;
    int              lat;
    bit              rnd;
    int              nops;
    logic [3:0][7:0] ops;
    int              exp_words;
    bit              exp_done;
    bit              exp_err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [127:0] glb_mem [256];
  logic [127:0] pend_dat [$];
  int           pend_due [$];
  logic [127:0] exp_q [$];

  logic [15:0]  cur_base = '0;
  int           req_idx  = 0;
  int           glb_lat  = 1;
  bit           rnd_mode = 0;
  bit           ccu_hold = 0;
  bit           track_occ = 0;
  int           hs_cnt, first_hs, last_hs, done_cnt, done_cyc, occ, max_occ;
  bit           prev_vld, prev_rdy, push_now, pop_now, ccu_rdy;
  logic [127:0] prev_dat, got_word;
  logic [15:0]  exp_addr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int bench_len(input logic [7:0] op);
    case (op)
      8'd0:    return 16;
      8'd1:    return 2;
      8'd2:    return 3;
      8'd3:    return 9;
      8'd4:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic vec_t mk(string nm, logic [15:0] b, logic [15:0] n, int lat, bit rnd,
                              int nops, logic [31:0] ops, int ew, bit ed, bit ee);
    vec_t r;
    r.name = nm; r.base = b; r.num = n; r.lat = lat; r.rnd = rnd;
    r.nops = nops; r.ops = ops; r.exp_words = ew; r.exp_done = ed; r.exp_err = ee;
    return r;
  endfunction

  // GLB responder and CCU sink; inputs change on the falling edge, away from DUT sampling.
  always @(negedge clk) begin
    if (rst) begin
      rd_dat_vld = 1'b0;
      rd_dat     = '0;
      prev_vld   = 1'b0;
    end else begin
      rd_addr_rdy = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_addr_vld && rd_addr_rdy) begin
        exp_addr = cur_base + req_idx[15:0];
        chk("rd_addr", 128'(rd_addr), 128'(exp_addr));
        pend_dat.push_back(glb_mem[rd_addr[7:0]]);
        pend_due.push_back(cyc + 1 + glb_lat);
        req_idx++;
      end
      push_now = 1'b0;
      if (pend_due.size() > 0 && pend_due[0] <= cyc + 1) begin
        rd_dat_vld = 1'b1;
        rd_dat     = pend_dat.pop_front();
        void'(pend_due.pop_front());
        push_now   = 1'b1;
      end else begin
        rd_dat_vld = 1'b0;
        rd_dat     = '0;
      end

      if (prev_vld && !prev_rdy) begin
        chk("vld_held", 128'(isa_vld), 128'(1));
        chk("dat_held", isa_dat, prev_dat);
      end
      ccu_rdy = ccu_hold ? 1'b0 : (rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1);
      isa_rdy = ccu_rdy;
      pop_now = 1'b0;
      if (isa_vld && isa_rdy) begin
        pop_now = 1'b1;
        hs_cnt++;
        if (first_hs < 0) first_hs = cyc + 1;
        last_hs = cyc + 1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_word: got %0h expected no word", isa_dat);
        end else begin
          got_word = exp_q.pop_front();
          chk("isa_word", isa_dat, got_word);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_vld = isa_vld;
      prev_rdy = ccu_rdy;
      prev_dat = isa_dat;
      if (track_occ) begin
        occ = occ + int'(push_now) - int'(pop_now);
        if (occ > max_occ) max_occ = occ;
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int w, s, t, len;
    logic [127:0] word;
    logic [15:0]  idx;
    w = 0;
    exp_q.delete();
    req_idx = 0; hs_cnt = 0; first_hs = -1; last_hs = -1; done_cnt = 0; done_cyc = -1;
    occ = 0; max_occ = 0;
    cur_base = v.base; glb_lat = v.lat; rnd_mode = v.rnd; track_occ = !v.exp_err;
    for (int k = 0; k < v.nops; k++) begin
      len = bench_len(v.ops[k]);
      for (int j = 0; j < len; j++) begin
        word = {$urandom, $urandom, $urandom, $urandom};
        if (j == 0) word[7:0] = v.ops[k];
        idx = v.base + w[15:0];
        glb_mem[idx[7:0]] = word;
        if (w < v.exp_words) exp_q.push_back(word);
        w++;
      end
    end
    base_in = v.base;
    num_in  = v.num;
    start   = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    chk({v.name, ".first_rd_vld"}, 128'(rd_addr_vld), 128'(v.num != 0));
    chk({v.name, ".err_clear_on_start"}, 128'(err), 128'(0));
    t = 0;
    while (done_cnt == 0 && err !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({v.name, ".no_timeout"}, 128'(t < 3000), 128'(1));
    repeat (30) @(negedge clk);
    chk({v.name, ".done_count"}, 128'(done_cnt), 128'(v.exp_done));
    chk({v.name, ".err"}, 128'(err), 128'(v.exp_err));
    chk({v.name, ".words_sent"}, 128'(hs_cnt), 128'(v.exp_words));
    chk({v.name, ".scoreboard_empty"}, 128'(exp_q.size()), 128'(0));
    if (!v.exp_err) chk({v.name, ".req_count"}, 128'(req_idx), 128'(v.num));
    else            chk({v.name, ".req_bounded"}, 128'(req_idx <= int'(v.num)), 128'(1));
    if (track_occ) chk({v.name, ".occupancy_le_4"}, 128'(max_occ <= 4), 128'(1));
    if (v.exp_done) chk({v.name, ".done_timing"}, 128'(done_cyc), 128'((v.num == 0) ? s + 1 : last_hs));
    if (!v.rnd && !v.exp_err && v.exp_words > 1)
      chk({v.name, ".throughput"}, 128'(last_hs - first_hs), 128'(v.exp_words - 1));
    rnd_mode = 0;
  endtask

  vec_t vecs [7];
  logic [127:0] w0;
  logic [7:0]   ix;

  initial begin
    rst = 1'b1; start = 1'b0; base_in = '0; num_in = '0;
    rd_addr_rdy = 1'b1; rd_dat_vld = 1'b0; rd_dat = '0; isa_rdy = 1'b1;
    for (int i = 0; i < 256; i++) glb_mem[i] = '0;

    vecs[0] = mk("single_knn", 16'h0010,  2, 1, 0, 1, 32'h00000001,  2, 1, 0);
    vecs[1] = mk("mixed",      16'h0100, 28, 2, 0, 3, 32'h00030200, 28, 1, 0);
    vecs[2] = mk("backpress",  16'h0200, 16, 3, 1, 4, 32'h03040201, 16, 1, 0);
    vecs[3] = mk("illegal_op", 16'h0300,  7, 2, 0, 2, 32'h00000702,  3, 0, 1);
    vecs[4] = mk("truncated",  16'h0400,  5, 1, 0, 1, 32'h00000000,  5, 0, 1);
    vecs[5] = mk("addr_wrap",  16'hFFFF,  2, 1, 0, 1, 32'h00000004,  2, 1, 0);
    vecs[6] = mk("zero_len",   16'h0020,  0, 1, 0, 0, 32'h00000000,  0, 1, 0);

    repeat (2) @(negedge clk);
    chk("rst.rd_addr_vld", 128'(rd_addr_vld), 128'(0));
    chk("rst.rd_addr",     128'(rd_addr),     128'(0));
    chk("rst.rd_dat_rdy",  128'(rd_dat_rdy),  128'(1));
    chk("rst.isa_vld",     128'(isa_vld),     128'(0));
    chk("rst.isa_dat",     isa_dat,           128'(0));
    chk("rst.done",        128'(done),        128'(0));
    chk("rst.err",         128'(err),         128'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset while a stalled run holds a full buffer.
    for (int j = 0; j < 16; j++) begin
      w0 = {$urandom, $urandom, $urandom, $urandom};
      if (j == 0) w0[7:0] = 8'd0;
      ix = 8'h40 + 8'(j);
      glb_mem[ix] = w0;
    end
    exp_q.delete();
    cur_base = 16'h0040; req_idx = 0; glb_lat = 2; rnd_mode = 0; ccu_hold = 1; track_occ = 0;
    base_in = 16'h0040; num_in = 16'd16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst.vld_before", 128'(isa_vld), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("midrst.rd_addr_vld", 128'(rd_addr_vld), 128'(0));
    chk("midrst.rd_addr",     128'(rd_addr),     128'(0));
    chk("midrst.rd_dat_rdy",  128'(rd_dat_rdy),  128'(1));
    chk("midrst.isa_vld",     128'(isa_vld),     128'(0));
    chk("midrst.isa_dat",     isa_dat,           128'(0));
    chk("midrst.done",        128'(done),        128'(0));
    chk("midrst.err",         128'(err),         128'(0));
    pend_dat.delete();
    pend_due.delete();
    rd_dat_vld = 1'b0;
    ccu_hold = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ccu_isa_fetch.md
# ccu_isa_fetch

Instruction-stream transmitter that feeds the CCU's ISA read port. On a start command it reads a program of PORT_WIDTH-bit ISA words from the GLB read port, buffers them, and streams them to the CCU with a valid/ready handshake. It tracks instruction framing via a per-opcode word-length table so that it can flag malformed programs. It sits in ITF between the GLB read channel and the CCU.

## Interface
- PORT_WIDTH, 128: ISA word width; matches the CCU input port.
- ADDR_WIDTH, 16: GLB word address and program-length width.
- OPCODE_WIDTH, 8: opcode field, located at word bits [OPCODE_WIDTH-1:0].
- NUM_OP, 5: number of legal opcodes (0..NUM_OP-1).
- LEN_FPS / LEN_KNN / LEN_SYA / LEN_POL / LEN_GIC, 16 / 2 / 3 / 9 / 2: words per instruction for opcodes 0..4.
- BUF_DEPTH, 4: output buffer depth in words; power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- TOPITF_IsaStart  in  1  start pulse; sampled only in IDLE.
- TOPITF_IsaBaseAddr  in  ADDR_WIDTH  first program word address; captured on start.
- TOPITF_IsaNumWord  in  ADDR_WIDTH  program length in words; captured on start; 0 is legal.
- ITFTOP_IsaDone  out  1  one-cycle pulse when the program has been fully sent.
- ITFTOP_IsaErr  out  1  sticky error flag; cleared by the next accepted start.
- ITFGLB_RdAddr  out  ADDR_WIDTH  read address.
- ITFGLB_RdAddrVld  out  1  read request valid.
- GLBITF_RdAddrRdy  in  1  read request accepted.
- GLBITF_RdDat  in  PORT_WIDTH  read data, returned in order.
- GLBITF_RdDatVld  in  1  read data valid.
- ITFGLB_RdDatRdy  out  1  tied high; the credit scheme guarantees buffer space.
- ITFCCU_ISARdDat  out  PORT_WIDTH  ISA word (head of buffer).
- ITFCCU_ISARdDatVld  out  1  ISA word valid.
- CCUITF_ISARdDatRdy  in  1  CCU accepts word.

## Operation
- FSM states: IDLE, RUN, ERR.
  - IDLE → RUN on start. Start also captures base address and length, clears counters, and clears Err.
  - If NumWord==0, IDLE pulses Done on the next cycle and stays in IDLE.
- RUN, request side:
  - Issue a read when issued<NumWord and credit is available: outstanding + bufCount < BUF_DEPTH.
  - Request handshake is RdAddrVld & RdAddrRdy.
  - RdAddr = base + issued. Address arithmetic is modulo 2^ADDR_WIDTH (wraps).
- RUN, buffer side:
  - Each RdDatVld pushes one word into the FWFT buffer and decrements outstanding.
  - Buffer occupancy never exceeds BUF_DEPTH.
- Framing:
  - wordCnt counts words sent within the current instruction; remLen is the words remaining in it.
  - When the buffer head is at wordCnt==0, it is a header. Decode opcode = head[OPCODE_WIDTH-1:0] and load remLen from the length table.
  - If opcode ≥ NUM_OP: go to ERR. The header is not presented (Vld stays 0).
  - Each output handshake (Vld & Rdy) pops the buffer and increments sent. When wordCnt reaches remLen, wordCnt resets to 0.
- Completion:
  - When sent==NumWord and wordCnt==0: pulse Done, go to IDLE.
  - When sent==NumWord and wordCnt≠0 (truncated instruction): go to ERR.
- ERR:
  - Err=1, Vld=0, no new requests.
  - Outstanding responses are absorbed and discarded.
  - Go to IDLE once outstanding==0. Err stays set.
- Start received while in RUN or ERR is ignored.

## Timing
- Reset values: RdAddrVld=0, RdAddr=0, RdDatRdy=1, ISARdDatVld=0, ISARdDat=0, Done=0, Err=0, FSM=IDLE, all counters 0.
- Reset mid-operation returns to IDLE immediately. The GLB shares rst, so no stale responses arrive after reset.
- First RdAddrVld is asserted the cycle after start.
- A word written by RdDatVld in cycle t is visible at the output in cycle t+1. Bypass is not allowed.
- Sustained throughput is 1 word/cycle with GLB latency ≤ BUF_DEPTH-1 and Rdy held high.
- Vld is held, with stable data, until Rdy. Vld never depends on Rdy.
- Simultaneous push and pop: occupancy is unchanged. Credit uses the registered outstanding and bufCount values, so a pop frees credit one cycle later.
- Done is asserted the cycle after the final handshake.

## Structure
- Shared package holds:
  - opcode constants (OPCODE_FPS=0 … OPCODE_GIC=4);
  - the per-opcode length table;
  - FSM state encodings.
- The CCU uses the same opcode constants from that package.
- One sub-module: the existing FIFO_FWFT (DATA_WIDTH=PORT_WIDTH, ADDR_WIDTH=log2(BUF_DEPTH)) for the output buffer. Drive its Reset input from rst.
- All other logic (FSM, issue and credit counters, framing) lives in ccu_isa_fetch.

## Test plan
- Single-instruction program: base=0x0010, NumWord=2, header opcode=1 (KNN), Rdy=1, GLB latency 1 → reads at 0x0010 and 0x0011, two output words in order, Done pulses once, Err=0.
- Mixed program: FPS, SYA and POL instructions = 28 words, Rdy=1, latency 2 → 28 ordered handshakes at 1 word/cycle after fill, Done pulses once.
- Backpressure: Rdy toggles randomly and GLB latency is 3 → no word dropped or duplicated, Vld and data stable while Rdy=0, buffer occupancy never exceeds 4.
- Illegal opcode 7 in the second header → first instruction fully sent, Vld stays 0 for the bad header, Err=1, FSM returns to IDLE after outstanding drains, no Done.
- Truncated program: NumWord=5 with an FPS header (needs 16) → 5 words sent, then Err=1, no Done; the next start clears Err.
- Edge cases:
  - base=0xFFFF, NumWord=2 → addresses 0xFFFF then 0x0000 (wrap).
  - NumWord=0 → Done one cycle after start, no reads issued.
  - rst asserted mid-RUN → all outputs at reset values within the same cycle.
